cu_sdf_stage: RTL

- Parametrised control unit for one radix-2 single-delay-feedback (SDF) FFT stage.
- Counts accepted samples and generates the butterfly enable, twiddle index and datapath advance strobe.
- Drains the feedback delay line at end of stream and produces frame-aligned valid/sof/eof for the next stage.
- Successor to the fixed 2-bit-counter stage controllers: generalised span, frame length and output latency, with ready/last handshake and drain FSM.

---
 rtl/fft_cu_pkg.sv | 30 +++
 rtl/cu_valid_dly.sv | 35 +++
 rtl/cu_sdf_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/fft_cu_pkg.sv
// Shared types and elaboration helpers for the radix-2 SDF stage controller.
// Width helpers take the module parameters because a package cannot see them.
package fft_cu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } cu_state_e;

   function automatic int cnt_w(input int frame_len);
      return $clog2(frame_len);
   endfunction

   function automatic int tw_w(input int half_len);
      return $clog2(half_len);
   endfunction

   function automatic bit is_pow2(input int x);
      return (x > 0) && ((x & (x - 1)) == 0);
   endfunction

   // Span and frame must be powers of two, and a frame must hold whole spans.
   function automatic bit cu_params_ok(input int half_len, input int frame_len,
                                       input int pipe_lat);
      return is_pow2(half_len) && (half_len >= 2) && is_pow2(frame_len) &&
             ((frame_len % (2 * half_len)) == 0) && (pipe_lat >= 0);
   endfunction

endpackage

// File: rtl/cu_valid_dly.sv
// Aligns the {valid, sof, eof} strobes with the datapath output by delaying
// them PIPE_LAT cycles; a zero latency collapses to plain wires.
import fft_cu_pkg::*;

module cu_valid_dly #(
   parameter int PIPE_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic vld_p0,
   input  logic sof_p0,
   input  logic eof_p0,
   output logic vld_dly,
   output logic sof_dly,
   output logic eof_dly
);

   if (PIPE_LAT == 0) begin : g_wire
      assign {vld_dly, sof_dly, eof_dly} = {vld_p0, sof_p0, eof_p0};
   end else begin : g_pipe
      logic [2:0] pipe_p [PIPE_LAT];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe_p[i] <= '0;
         end else begin
            pipe_p[0] <= {vld_p0, sof_p0, eof_p0};
            for (int i = 1; i < PIPE_LAT; i++) pipe_p[i] <= pipe_p[i-1];
         end
      end

      assign {vld_dly, sof_dly, eof_dly} = pipe_p[PIPE_LAT-1];
   end

endmodule

// File: rtl/cu_sdf_stage.sv
// Control unit for one radix-2 single-delay-feedback FFT stage: sample counting,
// butterfly/twiddle control, end-of-stream delay-line drain and output framing.
import fft_cu_pkg::*;

module cu_sdf_stage #(
   parameter int HALF_LEN  = 4,
   parameter int FRAME_LEN = 16,
   parameter int PIPE_LAT  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_in,
   input  logic                      last_in,
   output logic                      ready,
   output logic                      adv,
   output logic                      bf_en,
   output logic [tw_w(HALF_LEN)-1:0] tw_idx,
   output logic                      valid_out,
   output logic                      sof_out,
   output logic                      eof_out,
   output logic                      busy
);

   localparam int CNT_W  = cnt_w(FRAME_LEN);
   localparam int TW_W   = tw_w(HALF_LEN);
   localparam int FILL_W = $clog2(HALF_LEN + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HALF_LEN);
   localparam logic [TW_W-1:0]   DRN_LAST  = TW_W'(HALF_LEN - 1);

   if (!cu_params_ok(HALF_LEN, FRAME_LEN, PIPE_LAT)) begin : g_bad_params
      $error("cu_sdf_stage: illegal HALF_LEN/FRAME_LEN/PIPE_LAT combination");
   end

   cu_state_e         state;
   logic [CNT_W-1:0]  in_cnt;
   logic [CNT_W-1:0]  out_cnt;
   logic [FILL_W-1:0] fill_cnt;
   logic [TW_W-1:0]   drn_cnt;

   logic acc;
   logic draining;
   logic drain_done;
   logic frame_end;
   logic vld_p0;
   logic sof_p0;
   logic eof_p0;

   assign draining   = (state == DRAIN);
   assign ready      = !draining;
   assign acc        = valid_in & ready;
   assign adv        = acc | draining;
   assign busy       = (state != IDLE);
   assign drain_done = draining & (drn_cnt == DRN_LAST);
   assign frame_end  = acc & last_in & (in_cnt == CNT_LAST);

   // Second half of each span runs the butterfly; acc is never set in DRAIN.
   assign bf_en  = acc & in_cnt[TW_W];
   assign tw_idx = bf_en ? in_cnt[TW_W-1:0] : '0;

   // Output exists only once the delay line holds a full span.
   assign vld_p0 = adv & (fill_cnt == FILL_FULL);
   assign sof_p0 = vld_p0 & (out_cnt == '0);
   assign eof_p0 = vld_p0 & (out_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         in_cnt   <= '0;
         out_cnt  <= '0;
         fill_cnt <= '0;
         drn_cnt  <= '0;
      end else begin
         if (acc)    in_cnt  <= in_cnt + 1'b1;
         if (vld_p0) out_cnt <= out_cnt + 1'b1;

         if (drain_done)
            fill_cnt <= '0;
         else if (adv && (fill_cnt != FILL_FULL))
            fill_cnt <= fill_cnt + 1'b1;

         // Back-to-back frames never drain: the next frame pushes the tail out.
         case (state)
            IDLE: begin
               if (acc) state <= RUN;
            end
            RUN: begin
               if (frame_end) begin
                  state   <= DRAIN;
                  drn_cnt <= '0;
               end
            end
            DRAIN: begin
               if (drain_done) state   <= IDLE;
               else            drn_cnt <= drn_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---- stage boundary: strobes retimed to the datapath output ----
   cu_valid_dly #(
      .PIPE_LAT (PIPE_LAT)
   ) u_valid_dly (
      .clk     (clk),
      .rst     (rst),
      .vld_p0  (vld_p0),
      .sof_p0  (sof_p0),
      .eof_p0  (eof_p0),
      .vld_dly (valid_out),
      .sof_dly (sof_out),
      .eof_dly (eof_out)
   );

endmodule
